// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_if
// Description : Bundles the instruction-memory request/response channel, the
//               execute-stage redirect and the decode-stage handshake seen by
//               the fetch unit.
//               master : fetch unit side
//               slave  : memory / execute / decode environment side
// Revision    : 1.0 - initial release
// ============================================================================
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_instr;
  logic [63:0] id_pc;
  logic        fetch_misalign;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output fetch_misalign
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  fetch_misalign
  );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch unit. Owns the fetch PC, keeps at most one
//               instruction-memory read in flight, buffers returned words in a
//               2-entry FIFO and hands them with their PC to decode. Redirects
//               from execute flush the FIFO and drop any in-flight response.
//               Optional feature macro: IFU_MISALIGN_TRAP_EN
//                 defined   : misaligned redirect halts fetch and raises the
//                             sticky fetch_misalign flag
//                 undefined : redirect_pc[1:0] ignored, fetch_misalign = 0
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master fetch
);

  // Fetch states: issue a request, wait for its data, or wait for a
  // response that belongs to a flushed path and must be thrown away.
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
`ifdef IFU_MISALIGN_TRAP_EN
  localparam logic [1:0] S_HALT = 2'd3;
`endif

  // PCs are held as word addresses; the two low byte-address bits are
  // always zero on every fetch path.
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [61:0] r_fetch_pc;
  logic [61:0] r_req_pc;
  logic [1:0]  r_count;
  logic [61:0] r_pc0;
  logic [61:0] r_pc1;
  logic [31:0] r_data0;
  logic [31:0] r_data1;

  logic        w_redirect;
  logic [61:0] w_redirect_word;
  logic        w_free_ok;
  logic        w_req_valid;
  logic        w_req_hs;
  logic        w_rsp;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_redirect_dest;
  logic [1:0]  w_drop_exit;
  logic        w_misalign;

  assign w_redirect      = fetch.redirect_valid;
  assign w_redirect_word = fetch.redirect_pc[63:2];
  assign w_rsp           = fetch.imem_rsp_valid;

`ifdef IFU_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_bad_target;

  assign w_bad_target    = w_redirect && (fetch.redirect_pc[1:0] != 2'b00);
  // A misaligned target parks the unit in HALT; an aligned one resumes.
  assign w_redirect_dest = w_bad_target ? S_HALT : S_REQ;
  // A drop that was started by a misaligned redirect finishes into HALT.
  assign w_drop_exit     = r_misalign ? S_HALT : S_REQ;
  assign w_misalign      = r_misalign;

  // Sticky misalign flag: follows the alignment of the latest redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_redirect) begin
      r_misalign <= (fetch.redirect_pc[1:0] != 2'b00);
    end
  end
`else
  logic w_unused_lsb;

  // Without the trap the low target bits are simply discarded.
  assign w_unused_lsb    = ^fetch.redirect_pc[1:0];
  assign w_redirect_dest = S_REQ;
  assign w_drop_exit     = S_REQ;
  assign w_misalign      = 1'b0;
`endif

  // A request may only go out if its data is guaranteed a FIFO slot,
  // counting the slot reserved by a response still in flight.
  assign w_free_ok = ({1'b0, r_count} + {2'b00, (r_state == S_WAIT)}) < 3'd2;
  assign w_req_hs  = w_req_valid && fetch.imem_req_ready;

  // Responses are only enqueued on the live path; a redirect kills them.
  assign w_push = (r_state == S_WAIT) && w_rsp && !w_redirect;
  assign w_pop  = (r_count != 2'd0) && fetch.id_ready && !w_redirect;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: redirect has priority; an unanswered in-flight request
  // during a redirect turns into a drop so its data never reaches decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_redirect) begin
          w_state_nxt = w_redirect_dest;
        end else if (w_req_hs) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_state_nxt = w_rsp ? w_redirect_dest : S_DROP;
        end else if (w_rsp) begin
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (w_redirect) begin
          w_state_nxt = w_rsp ? w_redirect_dest : S_DROP;
        end else if (w_rsp) begin
          w_state_nxt = w_drop_exit;
        end
      end
`ifdef IFU_MISALIGN_TRAP_EN
      S_HALT: begin
        if (w_redirect) begin
          w_state_nxt = w_redirect_dest;
        end
      end
`endif
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // FSM outputs: request valid is withdrawn immediately on redirect/reset.
  always_comb begin
    w_req_valid = 1'b0;
    if (!rst && (r_state == S_REQ) && w_free_ok && !w_redirect) begin
      w_req_valid = 1'b1;
    end
  end

  // Fetch PC: redirect target wins, otherwise advance on each accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC[63:2];
    end else if (w_redirect) begin
      r_fetch_pc <= w_redirect_word;
    end else if (w_req_hs) begin
      r_fetch_pc <= r_fetch_pc + 62'd1;
    end
  end

  // Remember the PC of the request in flight so its response can be tagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pc <= RESET_PC[63:2];
    end else if (w_req_hs) begin
      r_req_pc <= r_fetch_pc;
    end
  end

  // Two-entry shifting FIFO; entry 0 is always the head seen by decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_pc0   <= '0;
      r_pc1   <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else if (w_redirect) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc0   <= r_req_pc;
            r_data0 <= fetch.imem_rsp_data;
          end else begin
            r_pc1   <= r_req_pc;
            r_data1 <= fetch.imem_rsp_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_pc0   <= r_pc1;
          r_data0 <= r_data1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_pc0   <= r_req_pc;
            r_data0 <= fetch.imem_rsp_data;
          end else begin
            r_pc0   <= r_pc1;
            r_data0 <= r_data1;
            r_pc1   <= r_req_pc;
            r_data1 <= fetch.imem_rsp_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fetch.imem_req_valid = w_req_valid;
  assign fetch.imem_req_addr  = {r_fetch_pc, 2'b00};
  assign fetch.id_valid       = (r_count != 2'd0);
  assign fetch.id_instr       = {32'h0000_0000, r_data0};
  assign fetch.id_pc          = {r_pc0, 2'b00};
  assign fetch.fetch_misalign = w_misalign;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch. A memory model answers
//               accepted reads after a programmable latency; a reference model
//               tracks the expected instruction stream (sequential PCs from the
//               last redirect or reset), the buffered-word count and whether a
//               stale response is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
`ifdef IFU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // memory model
  bit          mem_busy  = 1'b0;
  bit          mem_stale = 1'b0;
  int          mem_cnt   = 0;
  int          mem_lat   = 1;
  logic [63:0] mem_addr  = '0;

  // reference model
  int          tb_cnt     = 0;
  bit          halted     = 1'b0;
  logic [63:0] exp_pc     = RST_PC;
  logic [63:0] exp_req_pc = RST_PC;
  int          cyc        = 0;
  int          n_hs       = 0;
  int          n_pop      = 0;
  int          last_hs_cyc = 0;
  logic [63:0] last_hs_addr = '0;
  logic [63:0] hs_log[$];

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive the memory response, compare DUT against the
  // model, step the clock, then advance the model.
  task automatic tick();
    logic        hs, rsp, pop, push, exp_rv, redir;
    logic [63:0] tgt, addr_s;
    int          cur;
    bus.imem_rsp_valid = mem_busy && (mem_cnt == 0);
    bus.imem_rsp_data  = mem_busy ? word_of(mem_addr) : $urandom();
    #2;
    cur    = cyc;
    hs     = bus.imem_req_valid && bus.imem_req_ready;
    rsp    = bus.imem_rsp_valid;
    redir  = bus.redirect_valid;
    addr_s = bus.imem_req_addr;
    tgt    = TRAP ? bus.redirect_pc : {bus.redirect_pc[63:2], 2'b00};
    pop    = 1'b0;
    if (!rst) begin
      exp_rv = !mem_busy && !halted && !redir && (tb_cnt < 2);
      n_checks++;
      if (bus.imem_req_valid !== exp_rv)
        $display("FAIL req_valid cyc=%0d: got %b expected %b", cur, bus.imem_req_valid, exp_rv);
      else n_pass++;
      n_checks++;
      if (bus.id_valid !== (tb_cnt != 0))
        $display("FAIL id_valid cyc=%0d: got %b expected %b", cur, bus.id_valid, (tb_cnt != 0));
      else n_pass++;
      n_checks++;
      if (bus.fetch_misalign !== halted)
        $display("FAIL fetch_misalign cyc=%0d: got %b expected %b", cur, bus.fetch_misalign, halted);
      else n_pass++;
      if (hs) begin
        n_checks++;
        if (addr_s !== exp_req_pc)
          $display("FAIL req_addr cyc=%0d: got %h expected %h", cur, addr_s, exp_req_pc);
        else n_pass++;
      end
      pop = bus.id_valid && bus.id_ready && !redir;
      if (pop) begin
        n_checks++;
        if (bus.id_pc !== exp_pc)
          $display("FAIL id_pc cyc=%0d: got %h expected %h", cur, bus.id_pc, exp_pc);
        else n_pass++;
        n_checks++;
        if (bus.id_instr !== {32'h0, word_of(exp_pc)})
          $display("FAIL id_instr cyc=%0d: got %h expected %h", cur, bus.id_instr, {32'h0, word_of(exp_pc)});
        else n_pass++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mem_busy = 1'b0; mem_stale = 1'b0; tb_cnt = 0; halted = 1'b0;
      exp_pc = RST_PC; exp_req_pc = RST_PC;
    end else begin
      push = rsp && !mem_stale && !redir;
      if (pop) begin exp_pc += 64'd4; tb_cnt--; n_pop++; end
      if (push) tb_cnt++;
      if (rsp) begin mem_busy = 1'b0; mem_stale = 1'b0; end
      else if (mem_busy) mem_cnt--;
      if (redir) begin
        tb_cnt = 0; exp_pc = tgt; exp_req_pc = tgt;
        halted = TRAP && (tgt[1:0] != 2'b00);
        if (mem_busy) mem_stale = 1'b1;
      end
      if (hs) begin
        mem_busy = 1'b1; mem_stale = 1'b0; mem_cnt = mem_lat - 1; mem_addr = addr_s;
        exp_req_pc += 64'd4; n_hs++; last_hs_cyc = cur; last_hs_addr = addr_s;
        hs_log.push_back(addr_s);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (bus.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid); else n_pass++;
    n_checks++;
    if (bus.id_valid !== 1'b0) $display("FAIL rst_id_valid: got %b expected 0", bus.id_valid); else n_pass++;
    n_checks++;
    if (bus.id_instr !== 64'h0) $display("FAIL rst_id_instr: got %h expected 0", bus.id_instr); else n_pass++;
    n_checks++;
    if (bus.id_pc !== 64'h0) $display("FAIL rst_id_pc: got %h expected 0", bus.id_pc); else n_pass++;
    n_checks++;
    if (bus.fetch_misalign !== 1'b0) $display("FAIL rst_misalign: got %b expected 0", bus.fetch_misalign); else n_pass++;
    bus.imem_req_ready = 1'b1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b expected 1", bus.imem_req_valid); else n_pass++;
    n_checks++;
    if (bus.imem_req_addr !== RST_PC) $display("FAIL first_req_addr: got %h expected %h", bus.imem_req_addr, RST_PC); else n_pass++;
  endtask

  task automatic test_stream();
    int h0;
    hs_log.delete();
    mem_lat = 1; bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1;
    h0 = n_hs;
    repeat (20) tick();
    n_checks++;
    if (n_hs - h0 !== 10) $display("FAIL stream_throughput: got %0d requests expected 10", n_hs - h0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (hs_log[i] !== RST_PC + 64'(4 * i))
        $display("FAIL stream_addr%0d: got %h expected %h", i, hs_log[i], RST_PC + 64'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int p0, h0;
    bus.id_ready = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (bus.id_valid !== 1'b1) $display("FAIL bp_id_valid: got %b expected 1", bus.id_valid); else n_pass++;
    n_checks++;
    if (bus.imem_req_valid !== 1'b0) $display("FAIL bp_req_stall: got %b expected 0", bus.imem_req_valid); else n_pass++;
    bus.imem_req_ready = 1'b0; bus.id_ready = 1'b1;
    p0 = n_pop;
    repeat (4) tick();
    n_checks++;
    if (n_pop - p0 !== 2) $display("FAIL bp_buffered: got %0d words expected 2", n_pop - p0); else n_pass++;
    bus.imem_req_ready = 1'b1;
    h0 = n_hs;
    repeat (6) tick();
    n_checks++;
    if (!(n_hs > h0)) $display("FAIL bp_resume: got %0d requests expected >0", n_hs - h0); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int h0, a_cyc, k;
    mem_lat = 3; bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    h0 = n_hs; k = 0;
    while (n_hs == h0 && k < 20) begin tick(); k++; end
    n_checks++;
    if (n_hs == h0) $display("FAIL rdw_timeout: got no request expected one"); else n_pass++;
    a_cyc = last_hs_cyc;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    h0 = n_hs; k = 0;
    while (n_hs == h0 && k < 20) begin tick(); k++; end
    n_checks++;
    if (last_hs_cyc !== a_cyc + 4) $display("FAIL rdw_req_cycle: got %0d expected %0d", last_hs_cyc, a_cyc + 4); else n_pass++;
    n_checks++;
    if (last_hs_addr !== 64'h8000_0100) $display("FAIL rdw_req_addr: got %h expected %h", last_hs_addr, 64'h8000_0100); else n_pass++;
    repeat (10) tick();
  endtask

  task automatic test_redirect_collide();
    int k;
    mem_lat = 1; bus.id_ready = 1'b0; bus.imem_req_ready = 1'b1;
    repeat (8) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0300; bus.id_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b0; bus.id_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.id_valid !== 1'b0) $display("FAIL col2_id_valid: got %b expected 0", bus.id_valid); else n_pass++;
    n_checks++;
    if (bus.imem_req_addr !== 64'h8000_0300) $display("FAIL col2_addr: got %h expected %h", bus.imem_req_addr, 64'h8000_0300); else n_pass++;
    mem_lat = 2; k = 0;
    while (!(mem_busy && mem_cnt == 0 && tb_cnt == 1) && k < 20) begin tick(); k++; end
    n_checks++;
    if (!(mem_busy && mem_cnt == 0 && tb_cnt == 1)) $display("FAIL col1_setup_timeout: got cnt=%0d expected 1 with response due", tb_cnt); else n_pass++;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0400; bus.id_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.id_valid !== 1'b0) $display("FAIL col1_id_valid: got %b expected 0", bus.id_valid); else n_pass++;
    n_checks++;
    if (bus.imem_req_valid !== 1'b1) $display("FAIL col1_req_valid: got %b expected 1", bus.imem_req_valid); else n_pass++;
    n_checks++;
    if (bus.imem_req_addr !== 64'h8000_0400) $display("FAIL col1_addr: got %h expected %h", bus.imem_req_addr, 64'h8000_0400); else n_pass++;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_wait();
    int k;
    mem_lat = 3; bus.id_ready = 1'b0; bus.imem_req_ready = 1'b1; k = 0;
    while (!(tb_cnt == 1 && mem_busy) && k < 20) begin tick(); k++; end
    n_checks++;
    if (!(tb_cnt == 1 && mem_busy)) $display("FAIL rmw_setup_timeout: got cnt=%0d expected 1 in flight", tb_cnt); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.imem_req_valid !== 1'b0) $display("FAIL rmw_req_valid: got %b expected 0", bus.imem_req_valid); else n_pass++;
    n_checks++;
    if (bus.id_valid !== 1'b0) $display("FAIL rmw_id_valid: got %b expected 0", bus.id_valid); else n_pass++;
    n_checks++;
    if (bus.id_pc !== 64'h0) $display("FAIL rmw_id_pc: got %h expected 0", bus.id_pc); else n_pass++;
    n_checks++;
    if (bus.id_instr !== 64'h0) $display("FAIL rmw_id_instr: got %h expected 0", bus.id_instr); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req_addr !== RST_PC) $display("FAIL rmw_refetch_addr: got %h expected %h", bus.imem_req_addr, RST_PC); else n_pass++;
    bus.id_ready = 1'b1; mem_lat = 1;
    repeat (10) tick();
  endtask

`ifdef IFU_MISALIGN_TRAP_EN
  task automatic test_misalign();
    int k;
    bus.imem_req_ready = 1'b0; bus.id_ready = 1'b1; k = 0;
    while (mem_busy && k < 20) begin tick(); k++; end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0102;
    tick();
    bus.redirect_valid = 1'b0; bus.imem_req_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.fetch_misalign !== 1'b1) $display("FAIL mis_flag_set: got %b expected 1", bus.fetch_misalign); else n_pass++;
    repeat (5) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0200;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.fetch_misalign !== 1'b0) $display("FAIL mis_flag_clear: got %b expected 0", bus.fetch_misalign); else n_pass++;
    n_checks++;
    if (bus.imem_req_addr !== 64'h8000_0200) $display("FAIL mis_resume_addr: got %h expected %h", bus.imem_req_addr, 64'h8000_0200); else n_pass++;
    repeat (6) tick();
  endtask
`endif

  task automatic test_random();
    logic [63:0] t;
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.id_ready       = ($urandom_range(0, 2) != 0);
      mem_lat            = $urandom_range(1, 3);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      t = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
      if (!TRAP || $urandom_range(0, 3) == 0) t = t + 64'($urandom_range(0, 3));
      bus.redirect_pc = t;
      tick();
    end
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_collide();
    test_reset_mid_wait();
`ifdef IFU_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
